// File: rtl/epu_job_sched.sv
// Ed25519 verify sequencer: DEPTH-entry tagged job queue feeding the GFNV/GDSV engines.
// Optional per-phase watchdog enabled by defining EPU_TIMEOUT_EN.
module epu_job_sched #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [511:0]     in_sig,
  input  logic [255:0]     in_key,
  input  logic [255:0]     in_rhash,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic [1:0]       out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             gfnv_valid,
  output logic [255:0]     gfnv_key,
  input  logic             gfnv_done,
  input  logic             gfnv_error,
  input  logic [319:0]     gfnv_h_x,
  input  logic [319:0]     gfnv_h_y,
  input  logic [319:0]     gfnv_h_z,
  input  logic [319:0]     gfnv_h_t,
  output logic             gdsv_valid,
  output logic [255:0]     gdsv_a,
  output logic [255:0]     gdsv_b,
  output logic [319:0]     gdsv_A_X,
  output logic [319:0]     gdsv_A_Y,
  output logic [319:0]     gdsv_A_Z,
  output logic [319:0]     gdsv_A_T,
  input  logic             gdsv_done,
  input  logic [255:0]     gdsv_ge_bytes,
  output logic [1:0]       alu_sel,
  output logic             engine_abort
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [511:0]     sig;
    logic [255:0]     key;
    logic [255:0]     rhash;
    logic [TAG_W-1:0] tag;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FNV_START, S_FNV_RUN, S_DSV_RUN, S_RESP
  } state_t;

  state_t state_q, state_d;

  job_t          mem_q [DEPTH];
  job_t          act_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q;
  logic          push, pop, latch_h;

  logic [319:0]  ax_q, ay_q, az_q, at_q;

  logic             gfnv_valid_q, gfnv_valid_d;
  logic             gdsv_valid_q, gdsv_valid_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             out_result_q, out_result_d;
  logic [1:0]       out_err_q, out_err_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

`ifdef EPU_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 abort;
`endif

  assign push    = in_valid && in_ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d      = state_q;
    gfnv_valid_d = 1'b0;
    gdsv_valid_d = 1'b0;
    alu_sel_d    = alu_sel_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    out_tag_d    = out_tag_q;
    latch_h      = 1'b0;
`ifdef EPU_TIMEOUT_EN
    wdog_d       = wdog_q;
    abort        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_FNV_START;
      end
      S_FNV_START: begin
        gfnv_valid_d = 1'b1;
        alu_sel_d    = 2'b01;
        state_d      = S_FNV_RUN;
`ifdef EPU_TIMEOUT_EN
        wdog_d       = '0;
`endif
      end
      S_FNV_RUN: begin
        if (gfnv_done) begin
          if (gfnv_error) begin
            out_valid_d  = 1'b1;
            out_result_d = 1'b0;
            out_err_d    = 2'b01;
            out_tag_d    = act_q.tag;
            alu_sel_d    = 2'b00;
            state_d      = S_RESP;
          end else begin
            latch_h      = 1'b1;
            gdsv_valid_d = 1'b1;
            alu_sel_d    = 2'b10;
            state_d      = S_DSV_RUN;
`ifdef EPU_TIMEOUT_EN
            wdog_d       = '0;
`endif
          end
        end
`ifdef EPU_TIMEOUT_EN
        else if (wdog_q == '1) abort = 1'b1;
        else wdog_d = wdog_q + 1'b1;
`endif
      end
      S_DSV_RUN: begin
        if (gdsv_done) begin
          out_valid_d  = 1'b1;
          out_result_d = (gdsv_ge_bytes == act_q.sig[255:0]);
          out_err_d    = 2'b00;
          out_tag_d    = act_q.tag;
          alu_sel_d    = 2'b00;
          state_d      = S_RESP;
        end
`ifdef EPU_TIMEOUT_EN
        else if (wdog_q == '1) abort = 1'b1;
        else wdog_d = wdog_q + 1'b1;
`endif
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef EPU_TIMEOUT_EN
    // Expiry only reaches here when no done pulse arrived this cycle.
    if (abort) begin
      out_valid_d  = 1'b1;
      out_result_d = 1'b0;
      out_err_d    = 2'b10;
      out_tag_d    = act_q.tag;
      alu_sel_d    = 2'b00;
      state_d      = S_RESP;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b1;
      gfnv_valid_q <= 1'b0;
      gdsv_valid_q <= 1'b0;
      alu_sel_q    <= 2'b00;
      out_valid_q  <= 1'b0;
      out_result_q <= 1'b0;
      out_err_q    <= 2'b00;
      out_tag_q    <= '0;
`ifdef EPU_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      in_ready_q   <= (count_d != CW'(DEPTH));
      gfnv_valid_q <= gfnv_valid_d;
      gdsv_valid_q <= gdsv_valid_d;
      alu_sel_q    <= alu_sel_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      out_tag_q    <= out_tag_d;
`ifdef EPU_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  // Payload storage needs no reset: control state above gates every use.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{sig: in_sig, key: in_key, rhash: in_rhash, tag: in_tag};
    if (pop)  act_q <= mem_q[rd_ptr_q];
    if (latch_h) begin
      ax_q <= gfnv_h_x;
      ay_q <= gfnv_h_y;
      az_q <= gfnv_h_z;
      at_q <= gfnv_h_t;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign out_tag    = out_tag_q;
  assign gfnv_valid = gfnv_valid_q;
  assign gfnv_key   = act_q.key;
  assign gdsv_valid = gdsv_valid_q;
  assign gdsv_a     = act_q.rhash;
  assign gdsv_b     = act_q.sig[511:256];
  assign gdsv_A_X   = ax_q;
  assign gdsv_A_Y   = ay_q;
  assign gdsv_A_Z   = az_q;
  assign gdsv_A_T   = at_q;
  assign alu_sel    = alu_sel_q;
`ifdef EPU_TIMEOUT_EN
  assign engine_abort = abort;
`else
  assign engine_abort = 1'b0;
`endif

endmodule

// File: tb/tb_epu_job_sched.sv
// Directed self-checking bench for epu_job_sched; the watchdog case runs only with EPU_TIMEOUT_EN.
module tb_epu_job_sched;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [511:0]     in_sig = '0;
  logic [255:0]     in_key = '0;
  logic [255:0]     in_rhash = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_result;
  logic [1:0]       out_err;
  logic [TAG_W-1:0] out_tag;
  logic             gfnv_valid;
  logic [255:0]     gfnv_key;
  logic             gfnv_done = 1'b0;
  logic             gfnv_error = 1'b0;
  logic [319:0]     gfnv_h_x = 320'h1111, gfnv_h_y = 320'h2222;
  logic [319:0]     gfnv_h_z = 320'h3333, gfnv_h_t = 320'h4444;
  logic             gdsv_valid;
  logic [255:0]     gdsv_a, gdsv_b;
  logic [319:0]     gdsv_A_X, gdsv_A_Y, gdsv_A_Z, gdsv_A_T;
  logic             gdsv_done = 1'b0;
  logic [255:0]     gdsv_ge_bytes = '0;
  logic [1:0]       alu_sel;
  logic             engine_abort;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  epu_job_sched #(
    .DEPTH(4),
    .TAG_W(TAG_W),
`ifdef EPU_TIMEOUT_EN
    .TIMEOUT_W(4)
`else
    .TIMEOUT_W(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sig(in_sig), .in_key(in_key),
    .in_rhash(in_rhash), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_err(out_err), .out_tag(out_tag),
    .gfnv_valid(gfnv_valid), .gfnv_key(gfnv_key), .gfnv_done(gfnv_done),
    .gfnv_error(gfnv_error), .gfnv_h_x(gfnv_h_x), .gfnv_h_y(gfnv_h_y),
    .gfnv_h_z(gfnv_h_z), .gfnv_h_t(gfnv_h_t),
    .gdsv_valid(gdsv_valid), .gdsv_a(gdsv_a), .gdsv_b(gdsv_b),
    .gdsv_A_X(gdsv_A_X), .gdsv_A_Y(gdsv_A_Y), .gdsv_A_Z(gdsv_A_Z), .gdsv_A_T(gdsv_A_T),
    .gdsv_done(gdsv_done), .gdsv_ge_bytes(gdsv_ge_bytes),
    .alu_sel(alu_sel), .engine_abort(engine_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_sig(input int unsigned t);
    return {256'(t) * 256'h9E37 + 256'h5, 256'(t) * 256'hA5A5 + 256'h77};
  endfunction

  function automatic logic [255:0] mk_r(input int unsigned t);
    logic [511:0] s;
    s = mk_sig(t);
    return s[255:0];
  endfunction

  task automatic push(input int unsigned t);
    in_sig   = mk_sig(t);
    in_key   = 256'(t) ^ 256'hC0FFEE;
    in_rhash = 256'(t) + 256'h1000;
    in_tag   = TAG_W'(t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_gfnv(input string name);
    int unsigned n = 0;
    while (!gfnv_valid && n < 20) begin tick(); n++; end
    if (!gfnv_valid) check({name, "_gfnv_timeout"}, 0, 1);
  endtask

  task automatic wait_out(input string name);
    int unsigned n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) check({name, "_out_timeout"}, 0, 1);
  endtask

  task automatic finish_engines(input logic [255:0] ge);
    gfnv_done  = 1'b1;
    gfnv_error = 1'b0;
    tick();
    gfnv_done     = 1'b0;
    gdsv_done     = 1'b1;
    gdsv_ge_bytes = ge;
    tick();
    gdsv_done = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [511:0] s3;
    int unsigned  seen;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_gfnv_valid", gfnv_valid, 0);
    check("rst_abort", engine_abort, 0);

    // 1. Valid signature, start latency
    push(3);
    s3 = mk_sig(3);
    check("t1_gfnv_lat0", gfnv_valid, 0);
    tick();
    check("t1_gfnv_lat1", gfnv_valid, 0);
    tick();
    check("t1_gfnv_lat2", gfnv_valid, 1);
    check("t1_alu_fnv", alu_sel, 2'b01);
    check("t1_key", gfnv_key, 256'd3 ^ 256'hC0FFEE);
    tick();
    check("t1_gfnv_pulse", gfnv_valid, 0);
    gfnv_done = 1'b1;
    tick();
    gfnv_done = 1'b0;
    check("t1_gdsv_valid", gdsv_valid, 1);
    check("t1_alu_dsv", alu_sel, 2'b10);
    check("t1_A_X", gdsv_A_X, 320'h1111);
    check("t1_A_T", gdsv_A_T, 320'h4444);
    check("t1_gdsv_a", gdsv_a, 256'd3 + 256'h1000);
    check("t1_gdsv_b", gdsv_b, s3[511:256]);
    tick();
    check("t1_gdsv_pulse", gdsv_valid, 0);
    gdsv_done = 1'b1;
    gdsv_ge_bytes = s3[255:0];
    tick();
    gdsv_done = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_result", out_result, 1);
    check("t1_err", out_err, 2'b00);
    check("t1_tag", out_tag, 3);
    check("t1_alu_free", alu_sel, 0);
    tick();
    check("t1_hold", out_valid, 1);
    consume();
    check("t1_released", out_valid, 0);

    // 2. Key decode error
    push(5);
    wait_gfnv("t2");
    check("t2_alu_fnv", alu_sel, 2'b01);
    gfnv_done  = 1'b1;
    gfnv_error = 1'b1;
    tick();
    gfnv_done  = 1'b0;
    gfnv_error = 1'b0;
    check("t2_out_valid", out_valid, 1);
    check("t2_result", out_result, 0);
    check("t2_err", out_err, 2'b01);
    check("t2_tag", out_tag, 5);
    check("t2_alu_free", alu_sel, 0);
    check("t2_no_gdsv", gdsv_valid, 0);
    tick();
    check("t2_no_gdsv_late", gdsv_valid, 0);
    consume();

    // 3. R mismatch
    push(7);
    wait_gfnv("t3");
    finish_engines(mk_r(7) ^ 256'h1);
    wait_out("t3");
    check("t3_result", out_result, 0);
    check("t3_err", out_err, 2'b00);
    check("t3_tag", out_tag, 7);
    consume();

    // 4. Backpressure and FIFO order
    for (int i = 0; i < 5; i++) push(i);
    check("t4_full", in_ready, 0);
    in_sig = mk_sig(9); in_tag = 4'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_full_hold", in_ready, 0);
    finish_engines(mk_r(0));
    wait_out("t4_0");
    check("t4_tag0", out_tag, 0);
    check("t4_res0", out_result, 1);
    tick(); tick();
    check("t4_stall_valid", out_valid, 1);
    check("t4_stall_tag", out_tag, 0);
    check("t4_stall_full", in_ready, 0);
    consume();
    for (int k = 1; k < 5; k++) begin
      wait_gfnv("t4");
      if (k == 1) check("t4_slot_free", in_ready, 1);
      finish_engines(mk_r(k));
      wait_out("t4");
      check($sformatf("t4_tag%0d", k), out_tag, k);
      check($sformatf("t4_res%0d", k), out_result, 1);
      consume();
    end
    tick(); tick(); tick();
    check("t4_drained", gfnv_valid | out_valid, 0);

    // 5. Reset mid DSV_RUN with two jobs queued
    push(10); push(11); push(12);
    wait_gfnv("t5");
    gfnv_done = 1'b1;
    tick();
    gfnv_done = 1'b0;
    check("t5_in_dsv", alu_sel, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_alu", alu_sel, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin gfnv_done = 1'b1; gdsv_done = 1'b1; end
      if (i == 4) begin gfnv_done = 1'b0; gdsv_done = 1'b0; end
      tick();
      if (out_valid || gfnv_valid || gdsv_valid || alu_sel != 2'b00) seen++;
    end
    check("t5_quiet", seen, 0);

`ifdef EPU_TIMEOUT_EN
    // 6. Watchdog expiry in DSV_RUN
    push(6);
    wait_gfnv("t6");
    gfnv_done = 1'b1;
    tick();
    gfnv_done = 1'b0;
    check("t6_gdsv_valid", gdsv_valid, 1);
    seen = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (engine_abort && seen == 0) seen = n;
      if (engine_abort) break;
    end
    check("t6_abort_delay", seen, 15);
    tick();
    check("t6_abort_pulse", engine_abort, 0);
    check("t6_out_valid", out_valid, 1);
    check("t6_err", out_err, 2'b10);
    check("t6_result", out_result, 0);
    check("t6_tag", out_tag, 6);
    check("t6_alu", alu_sel, 0);
    gdsv_done = 1'b1;
    gdsv_ge_bytes = mk_r(6);
    tick();
    gdsv_done = 1'b0;
    check("t6_late_done_err", out_err, 2'b10);
    check("t6_late_done_res", out_result, 0);
    consume();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
